// File: rtl/uart_32bit_deserializer.sv
// Packs four UART RX bytes MSB-first into a 32-bit word and writes it to a FIFO.
// A partial word left idle for TIMEOUT_CYCLES cycles is discarded so the stream re-aligns.
module uart_32bit_deserializer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned DROP_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            uart_data_in,
  input  logic                  uart_valid,
  output logic [31:0]           fifo_wr_data,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  rx_busy,
  output logic                  timeout_pulse,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned           CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  typedef enum logic [2:0] {
    S_B3   = 3'd0,
    S_B2   = 3'd1,
    S_B1   = 3'd2,
    S_B0   = 3'd3,
    S_PUSH = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             word_q, word_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [31:0]             wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;

  // Next-state, byte packing, idle timeout and drop accounting.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    timeout_d = 1'b0;
    drop_d    = drop_q;

    case (state_q)
      S_B3: begin
        cnt_d = '0;
        if (uart_valid) begin
          word_d[31:24] = uart_data_in;
          state_d       = S_B2;
        end else begin
          state_d = S_B3;
        end
      end
      S_B2, S_B1, S_B0: begin
        if (uart_valid) begin
          cnt_d = '0;
          case (state_q)
            S_B2: begin
              word_d[23:16] = uart_data_in;
              state_d       = S_B1;
            end
            S_B1: begin
              word_d[15:8] = uart_data_in;
              state_d      = S_B0;
            end
            default: begin
              word_d[7:0] = uart_data_in;
              state_d     = S_PUSH;
            end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          // A byte arriving on the expiry cycle wins; only a fully idle run times out.
          cnt_d     = '0;
          word_d    = 32'h0000_0000;
          timeout_d = 1'b1;
          state_d   = S_B3;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      S_PUSH: begin
        cnt_d = '0;
        if (uart_valid && (drop_q != DROP_MAX)) begin
          drop_d = drop_q + DROP_CNT_W'(1'b1);
        end else begin
          drop_d = drop_q;
        end
        if (!fifo_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = word_q;
          state_d   = S_B3;
        end else begin
          state_d = S_PUSH;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_B3;
      end
    endcase

    busy_d = (state_d != S_B3);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_B3;
      word_q    <= 32'h0000_0000;
      cnt_q     <= '0;
      wr_data_q <= 32'h0000_0000;
      wr_en_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign fifo_wr_data  = wr_data_q;
  assign fifo_wr_en    = wr_en_q;
  assign timeout_pulse = timeout_q;
  assign rx_busy       = busy_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_uart_32bit_deserializer.sv
// Self-checking bench: word table, hand-written corner sequences, and randomized traffic
// compared cycle by cycle against a byte-queue reference model.
module tb_uart_32bit_deserializer;

  localparam int unsigned TOUT   = 16;
  localparam int unsigned DROP_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        uart_data_in = 8'h00;
  logic              uart_valid = 1'b0;
  logic [31:0]       fifo_wr_data;
  logic              fifo_wr_en;
  logic              fifo_full = 1'b0;
  logic              rx_busy;
  logic              timeout_pulse;
  logic [DROP_W-1:0] drop_count;

  uart_32bit_deserializer #(.TIMEOUT_CYCLES(TOUT), .DROP_CNT_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .uart_data_in(uart_data_in), .uart_valid(uart_valid),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .rx_busy(rx_busy), .timeout_pulse(timeout_pulse), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: bytes of the current partial word, one pending word, idle run length.
  byte unsigned      m_part[$];
  bit                m_pend;
  longint unsigned   m_word;
  int                m_idle;
  int                m_drop;
  bit                m_wr_en, m_to, m_busy;
  longint unsigned   m_wr_data;

  // Observed activity.
  logic [31:0] wr_q[$];
  int          to_cnt = 0;
  int          edge_n = 0;
  int          last_wr_edge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_step(input bit v, input byte unsigned d, input bit f, input bit r);
    m_wr_en = 1'b0;
    m_to    = 1'b0;
    if (r) begin
      m_part.delete();
      m_pend = 1'b0; m_idle = 0; m_drop = 0; m_wr_data = 0;
    end else if (m_pend) begin
      if (v && m_drop < (2 ** DROP_W) - 1) m_drop++;
      if (!f) begin
        m_wr_en = 1'b1; m_wr_data = m_word; m_pend = 1'b0;
      end
    end else if (v) begin
      m_part.push_back(d);
      m_idle = 0;
      if (m_part.size() == 4) begin
        m_word = m_part[0] * 64'd16777216 + m_part[1] * 64'd65536 + m_part[2] * 64'd256 + m_part[3];
        m_pend = 1'b1;
        m_part.delete();
      end
    end else if (m_part.size() > 0) begin
      m_idle++;
      if (m_idle == TOUT) begin
        m_part.delete(); m_idle = 0; m_to = 1'b1;
      end
    end
    m_busy = m_pend || (m_part.size() > 0);
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input bit f);
    @(negedge clk);
    uart_valid = v; uart_data_in = d; fifo_full = f;
    model_step(v, d, f, rst);
    @(posedge clk);
    #1;
    edge_n++;
    chk("wr_en", {31'd0, fifo_wr_en}, {31'd0, m_wr_en});
    if (m_wr_en) chk("wr_data", fifo_wr_data, m_wr_data[31:0]);
    chk("rx_busy", {31'd0, rx_busy}, {31'd0, m_busy});
    chk("timeout_pulse", {31'd0, timeout_pulse}, {31'd0, m_to});
    chk("drop_count", {28'd0, drop_count}, m_drop);
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_wr_data);
      last_wr_edge = edge_n;
    end
    if (timeout_pulse) to_cnt++;
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, f);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    wr_q.delete();
    to_cnt = 0;
  endtask

  typedef struct {
    logic [7:0]  b3, b2, b1, b0;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int ef_edge;
    int seen;

    vecs[0] = '{8'h12, 8'h34, 8'h56, 8'h78, 0,  32'h1234_5678};
    vecs[1] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 1,  32'hA55A_FF00};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h01, 7,  32'h0000_0001};
    vecs[3] = '{8'h80, 8'h7F, 8'hC3, 8'h3C, 15, 32'h807F_C33C};
    vecs[4] = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 14, 32'hFEDC_BA98};

    do_reset();
    chk("reset_wr_data", fifo_wr_data, 32'h0000_0000);
    chk("reset_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("reset_busy", {31'd0, rx_busy}, 32'd0);
    chk("reset_drop", {28'd0, drop_count}, 32'd0);

    // Table: four bytes separated by idle gaps shorter than the timeout.
    for (int k = 0; k < 5; k++) begin
      wr_q.delete(); to_cnt = 0;
      tick(1'b1, vecs[k].b3, 1'b0); idle(vecs[k].gap, 1'b0);
      tick(1'b1, vecs[k].b2, 1'b0); idle(vecs[k].gap, 1'b0);
      tick(1'b1, vecs[k].b1, 1'b0); idle(vecs[k].gap, 1'b0);
      tick(1'b1, vecs[k].b0, 1'b0);
      idle(3, 1'b0);
      chk("tbl_wr_count", wr_q.size(), 32'd1);
      if (wr_q.size() > 0) chk("tbl_wr_data", wr_q[0], vecs[k].exp);
      chk("tbl_no_timeout", to_cnt, 32'd0);
    end

    // 1: basic word and write latency (strobe edge E -> fifo_wr_en high after edge E+1).
    do_reset();
    tick(1'b1, 8'hDE, 1'b0); tick(1'b1, 8'hAD, 1'b0); tick(1'b1, 8'hBE, 1'b0);
    tick(1'b1, 8'hEF, 1'b0);
    ef_edge = edge_n;
    idle(4, 1'b0);
    chk("t1_wr_count", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) chk("t1_wr_data", wr_q[0], 32'hDEAD_BEEF);
    chk("t1_latency", last_wr_edge - ef_edge, 32'd1);

    // 2: back-to-back; the byte right after a completed word hits the dead slot.
    do_reset();
    tick(1'b1, 8'h01, 1'b0); tick(1'b1, 8'h02, 1'b0); tick(1'b1, 8'h03, 1'b0);
    tick(1'b1, 8'h04, 1'b0);
    tick(1'b1, 8'h05, 1'b0);
    tick(1'b1, 8'h05, 1'b0); tick(1'b1, 8'h06, 1'b0); tick(1'b1, 8'h07, 1'b0);
    tick(1'b1, 8'h08, 1'b0);
    idle(3, 1'b0);
    chk("t2_wr_count", wr_q.size(), 32'd2);
    if (wr_q.size() > 1) begin
      chk("t2_word0", wr_q[0], 32'h0102_0304);
      chk("t2_word1", wr_q[1], 32'h0506_0708);
    end
    chk("t2_drop", {28'd0, drop_count}, 32'd1);

    // 3: FIFO full holds the word; bytes meanwhile are dropped.
    do_reset();
    tick(1'b1, 8'hCA, 1'b0); tick(1'b1, 8'hFE, 1'b0); tick(1'b1, 8'hF0, 1'b0);
    tick(1'b1, 8'h0D, 1'b1);
    tick(1'b1, 8'h11, 1'b1); tick(1'b1, 8'h22, 1'b1); tick(1'b1, 8'h33, 1'b1);
    idle(TOUT + 4, 1'b1);
    chk("t3_held_busy", {31'd0, rx_busy}, 32'd1);
    chk("t3_no_write_while_full", wr_q.size(), 32'd0);
    idle(3, 1'b0);
    chk("t3_drop", {28'd0, drop_count}, 32'd3);
    chk("t3_wr_count", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) chk("t3_wr_data", wr_q[0], 32'hCAFE_F00D);
    chk("t3_busy_after", {31'd0, rx_busy}, 32'd0);
    chk("t3_no_timeout", to_cnt, 32'd0);

    // 4: timeout discards the partial word, then the stream re-aligns.
    do_reset();
    tick(1'b1, 8'hAA, 1'b0); tick(1'b1, 8'hBB, 1'b0);
    idle(TOUT, 1'b0);
    chk("t4_timeout_count", to_cnt, 32'd1);
    chk("t4_busy", {31'd0, rx_busy}, 32'd0);
    tick(1'b1, 8'h11, 1'b0); tick(1'b1, 8'h22, 1'b0); tick(1'b1, 8'h33, 1'b0);
    tick(1'b1, 8'h44, 1'b0);
    idle(3, 1'b0);
    chk("t4_wr_count", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) chk("t4_wr_data", wr_q[0], 32'h1122_3344);

    // 5: byte arriving on the last idle cycle prevents the timeout.
    do_reset();
    tick(1'b1, 8'hAA, 1'b0); tick(1'b1, 8'hBB, 1'b0);
    idle(TOUT - 1, 1'b0);
    tick(1'b1, 8'hCC, 1'b0);
    tick(1'b1, 8'hDD, 1'b0);
    idle(3, 1'b0);
    chk("t5_no_timeout", to_cnt, 32'd0);
    chk("t5_wr_count", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) chk("t5_wr_data", wr_q[0], 32'hAABB_CCDD);

    // 6: reset mid-word.
    do_reset();
    tick(1'b1, 8'h12, 1'b0); tick(1'b1, 8'h34, 1'b0);
    do_reset();
    chk("t6_busy", {31'd0, rx_busy}, 32'd0);
    chk("t6_wr_data", fifo_wr_data, 32'h0000_0000);
    chk("t6_pulse", {31'd0, timeout_pulse}, 32'd0);
    tick(1'b1, 8'h9A, 1'b0); tick(1'b1, 8'hBC, 1'b0); tick(1'b1, 8'hDE, 1'b0);
    tick(1'b1, 8'hF0, 1'b0);
    idle(3, 1'b0);
    chk("t6_wr_count", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) chk("t6_wr_data_after", wr_q[0], 32'h9ABC_DEF0);

    // 7: drop counter saturates at all-ones.
    do_reset();
    tick(1'b1, 8'h01, 1'b1); tick(1'b1, 8'h02, 1'b1); tick(1'b1, 8'h03, 1'b1);
    tick(1'b1, 8'h04, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b1, 8'(i), 1'b1);
    chk("t7_drop_sat", {28'd0, drop_count}, 32'd15);
    idle(3, 1'b0);
    chk("t7_wr_count", wr_q.size(), 32'd1);
    if (wr_q.size() > 0) chk("t7_wr_data", wr_q[0], 32'h0102_0304);

    // Randomized traffic across valid/full density phases.
    do_reset();
    seen = 0;
    for (int p = 0; p < 8; p++) begin
      int pv;
      int pf;
      pv = (p % 4 == 0) ? 4 : (p % 4 == 1) ? 30 : (p % 4 == 2) ? 70 : 100;
      pf = (p < 4) ? 10 : 60;
      for (int c = 0; c < 400; c++) begin
        tick(($urandom % 100) < pv, 8'($urandom), ($urandom % 100) < pf);
      end
      if (p == 3) do_reset();
    end
    idle(TOUT + 4, 1'b0);
    seen = wr_q.size();
    chk("rand_writes_seen", {31'd0, seen > 0}, 32'd1);
    chk("rand_timeouts_seen", {31'd0, to_cnt > 0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
